// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Writer side of the instruction path. Receives a program image as a byte
//   stream from the host link, assembles 9-bit machine-code words, writes them
//   into the instruction memory, and keeps the core stalled until the whole
//   image has arrived with a matching checksum.
//
//   Stream: LEN_LO, LEN_HI (word count N), N x {instr[7:0], {7'b0, instr[8]}},
//           CHK (XOR of the 2N instruction bytes; length bytes excluded).
//
// Ports
//   Clk         in   system clock, all state on the rising edge
//   Reset_n     in   asynchronous active-low reset
//   Start       in   single-cycle pulse, begins a load from IDLE/DONE/ERR
//   RxValid     in   RxData carries a valid byte
//   RxData      in   stream byte
//   RxReady     out  byte accepted this cycle when RxValid & RxReady
//   ImemWrEn    out  instruction memory write strobe
//   ImemAddr    out  instruction memory write address
//   ImemWrData  out  9-bit instruction word
//   CoreHold    out  keep the fetch unit / core stalled
//   Done        out  image loaded and checksum good (sticky)
//   Error       out  load failed (sticky)
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              RxValid,
    input  logic [7:0]        RxData,
    output logic              RxReady,
    output logic              ImemWrEn,
    output logic [ADDR_W-1:0] ImemAddr,
    output logic [8:0]        ImemWrData,
    output logic              CoreHold,
    output logic              Done,
    output logic              Error
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LEN_LO = 4'd1;
    localparam logic [3:0] S_LEN_HI = 4'd2;
    localparam logic [3:0] S_INS_LO = 4'd3;
    localparam logic [3:0] S_INS_HI = 4'd4;
    localparam logic [3:0] S_WRITE  = 4'd5;
    localparam logic [3:0] S_CHECK  = 4'd6;
    localparam logic [3:0] S_DONE   = 4'd7;
    localparam logic [3:0] S_ERR    = 4'd8;

    // Capacity in 17 bits so it can be compared against any 16-bit length.
    localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

    // Running checksum fold: one byte XORed into the accumulator.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        chk_fold = acc ^ b;
    endfunction

    // States in which the loader is willing to take a stream byte.
    function automatic logic is_rx_state(input logic [3:0] st);
        case (st)
            S_LEN_LO, S_LEN_HI, S_INS_LO, S_INS_HI, S_CHECK: is_rx_state = 1'b1;
            default:                                         is_rx_state = 1'b0;
        endcase
    endfunction

    logic [3:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        chk_q, chk_d;
    logic [7:0]        lo_q, lo_d;
    logic [8:0]        wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wren_q, wren_d;
    logic              rdy_q, rdy_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept_s;
    logic [15:0]       len_n_s;
    logic [ADDR_W:0]   cnt_inc_s;

    // rdy_q mirrors is_rx_state(state_q), so it is a valid handshake qualifier.
    assign accept_s  = RxValid & rdy_q;
    assign len_n_s   = {RxData, len_q[7:0]};
    assign cnt_inc_s = cnt_q + CNT_ONE;

    // Next-state and datapath decisions for the load sequence.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) begin
                    state_d = S_LEN_LO;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    chk_d   = 8'h00;
                    hold_d  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_LO: begin
                if (accept_s) begin
                    len_d[7:0] = RxData;
                    state_d    = S_LEN_HI;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_HI: begin
                if (accept_s) begin
                    len_d[15:8] = RxData;
                    if ((len_n_s == 16'd0) || ({1'b0, len_n_s} > MAX_WORDS)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end else begin
                        state_d = S_INS_LO;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_INS_LO: begin
                if (accept_s) begin
                    lo_d    = RxData;
                    chk_d   = chk_fold(chk_q, RxData);
                    state_d = S_INS_HI;
                end else begin
                    state_d = state_q;
                end
            end
            S_INS_HI: begin
                if (accept_s) begin
                    // Only bit 0 of the HI byte is meaningful; anything else is a framing error.
                    if (RxData[7:1] != 7'd0) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end else begin
                        wdata_d = {RxData[0], lo_q};
                        // cnt_q < N <= MAX_WORDS here, so the low bits are the address.
                        addr_d  = cnt_q[ADDR_W-1:0];
                        chk_d   = chk_fold(chk_q, RxData);
                        state_d = S_WRITE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_inc_s;
                if (17'(cnt_inc_s) == {1'b0, len_q}) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_INS_LO;
                end
            end
            S_CHECK: begin
                if (accept_s) begin
                    if (RxData == chk_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                // Unreachable encoding: park safely with the core held.
                state_d = S_IDLE;
                hold_d  = 1'b1;
            end
        endcase

        rdy_d  = is_rx_state(state_d);
        wren_d = (state_d == S_WRITE);
    end

    // State and output registers; reset aborts any load in progress at once.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            len_q   <= 16'h0000;
            cnt_q   <= '0;
            chk_q   <= 8'h00;
            lo_q    <= 8'h00;
            wdata_q <= 9'h000;
            addr_q  <= '0;
            wren_q  <= 1'b0;
            rdy_q   <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            wren_q  <= wren_d;
            rdy_q   <= rdy_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign RxReady    = rdy_q;
    assign ImemWrEn   = wren_q;
    assign ImemAddr   = addr_q;
    assign ImemWrData = wdata_q;
    assign CoreHold   = hold_q;
    assign Done       = done_q;
    assign Error      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//   Scoreboard bench for prog_loader. Two instances: A at the default address
//   width, B at ADDR_W=4 for the capacity boundary. Stimulus tasks push the
//   expected writes/results; per-instance monitors pop and compare whenever
//   the DUT strobes a write or raises Done/Error.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    typedef struct {
        int a;
        int d;
    } wr_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       rxvalid;
    logic [7:0] rxdata;
    logic       sel;     // 0 drives instance A, 1 drives instance B

    logic       rdy_a, wr_a, hold_a, done_a, err_a;
    logic [9:0] addr_a;
    logic [8:0] data_a;
    logic       rdy_b, wr_b, hold_b, done_b, err_b;
    logic [3:0] addr_b;
    logic [8:0] data_b;

    int total;
    int fails;

    wr_t qa[$];
    wr_t qb[$];
    int  ra[$];
    int  rb[$];

    localparam int RES_DONE = 1;
    localparam int RES_ERR  = 2;

    prog_loader dut_a (
        .Clk(clk), .Reset_n(rst_n), .Start(start & ~sel), .RxValid(rxvalid & ~sel),
        .RxData(rxdata), .RxReady(rdy_a), .ImemWrEn(wr_a), .ImemAddr(addr_a),
        .ImemWrData(data_a), .CoreHold(hold_a), .Done(done_a), .Error(err_a)
    );

    prog_loader #(.ADDR_W(4)) dut_b (
        .Clk(clk), .Reset_n(rst_n), .Start(start & sel), .RxValid(rxvalid & sel),
        .RxData(rxdata), .RxReady(rdy_b), .ImemWrEn(wr_b), .ImemAddr(addr_b),
        .ImemWrData(data_b), .CoreHold(hold_b), .Done(done_b), .Error(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor A: writes and result events against the scoreboard.
    logic pd_a = 1'b0, pe_a = 1'b0;
    always @(negedge clk) begin
        wr_t e;
        if (wr_a) begin
            check("ready_low_in_write_a", int'(rdy_a), 0);
            total++;
            if (qa.size() == 0) begin
                fails++;
                $display("FAIL write_a: unexpected write addr 0x%0h data 0x%0h", addr_a, data_a);
            end else begin
                e = qa.pop_front();
                if (int'(addr_a) != e.a || int'(data_a) != e.d) begin
                    fails++;
                    $display("FAIL write_a: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             addr_a, data_a, e.a, e.d);
                end
            end
        end
        if ((done_a && !pd_a) || (err_a && !pe_a)) begin
            total++;
            if (ra.size() == 0) begin
                fails++;
                $display("FAIL result_a: unexpected done=%0b error=%0b", done_a, err_a);
            end else if ({30'd0, err_a, done_a} != ra.pop_front()) begin
                fails++;
                $display("FAIL result_a: got done=%0b error=%0b (wrong outcome)", done_a, err_a);
            end
        end
        pd_a = done_a;
        pe_a = err_a;
    end

    // Monitor B: same checks for the narrow instance.
    logic pd_b = 1'b0, pe_b = 1'b0;
    always @(negedge clk) begin
        wr_t e;
        if (wr_b) begin
            check("ready_low_in_write_b", int'(rdy_b), 0);
            total++;
            if (qb.size() == 0) begin
                fails++;
                $display("FAIL write_b: unexpected write addr 0x%0h data 0x%0h", addr_b, data_b);
            end else begin
                e = qb.pop_front();
                if (int'(addr_b) != e.a || int'(data_b) != e.d) begin
                    fails++;
                    $display("FAIL write_b: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             addr_b, data_b, e.a, e.d);
                end
            end
        end
        if ((done_b && !pd_b) || (err_b && !pe_b)) begin
            total++;
            if (rb.size() == 0) begin
                fails++;
                $display("FAIL result_b: unexpected done=%0b error=%0b", done_b, err_b);
            end else if ({30'd0, err_b, done_b} != rb.pop_front()) begin
                fails++;
                $display("FAIL result_b: got done=%0b error=%0b (wrong outcome)", done_b, err_b);
            end
        end
        pd_b = done_b;
        pe_b = err_b;
    end

    task automatic exp_wr(input int a, input int d);
        wr_t e;
        e.a = a;
        e.d = d;
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
    endtask

    task automatic exp_res(input int code);
        if (sel) rb.push_back(code);
        else     ra.push_back(code);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that took the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rxvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rxvalid = 1'b1;
        rxdata  = b;
        n = 0;
        forever begin
            @(negedge clk);
            if ((sel ? rdy_b : rdy_a) == 1'b1) break;
            n++;
            if (n > 40) break;
        end
        if (n > 40) begin
            total++;
            fails++;
            $display("FAIL send_byte: byte 0x%0h never accepted", b);
        end
        @(posedge clk);
        #1;
        rxvalid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic settle(input string name);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_pending_results"}, sel ? rb.size() : ra.size(), 0);
        check({name, "_pending_writes"}, sel ? qb.size() : qa.size(), 0);
    endtask

    task automatic nominal(input int gap);
        pulse_start();
        send_byte(8'h02, gap); send_byte(8'h00, gap);
        exp_wr(0, 'h134);
        send_byte(8'h34, gap); send_byte(8'h01, gap);
        exp_wr(1, 'h080);
        send_byte(8'h80, gap); send_byte(8'h00, gap);
        exp_res(RES_DONE);
        send_byte(8'hB5, gap);
    endtask

    initial begin
        logic [7:0] ck;
        logic [8:0] w;
        total   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        rxvalid = 1'b0;
        rxdata  = 8'h00;
        sel     = 1'b0;
        #20;
        check("rst_ready", int'(rdy_a), 0);
        check("rst_wren", int'(wr_a), 0);
        check("rst_addr", int'(addr_a), 0);
        check("rst_wdata", int'(data_a), 0);
        check("rst_hold", int'(hold_a), 1);
        check("rst_done", int'(done_a), 0);
        check("rst_error", int'(err_a), 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal load, back-to-back bytes.
        nominal(0);
        settle("nominal");
        check("nominal_done", int'(done_a), 1);
        check("nominal_hold", int'(hold_a), 0);
        check("nominal_error", int'(err_a), 0);

        // Same image with 3-cycle gaps, restarting from DONE.
        nominal(3);
        settle("gaps");
        check("gaps_done", int'(done_a), 1);
        check("gaps_hold", int'(hold_a), 0);

        // Zero length.
        pulse_start();
        check("start_clears_done", int'(done_a), 0);
        check("start_sets_hold", int'(hold_a), 1);
        exp_res(RES_ERR);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        settle("len_zero");
        check("len_zero_error", int'(err_a), 1);

        // Illegal HI byte: no write for that word.
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        exp_res(RES_ERR);
        send_byte(8'h03, 0);
        settle("bad_hi");
        check("bad_hi_done", int'(done_a), 0);

        // Checksum off by one bit: both words written, then Error.
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        exp_wr(0, 'h134);
        send_byte(8'h34, 0); send_byte(8'h01, 0);
        exp_wr(1, 'h080);
        send_byte(8'h80, 0); send_byte(8'h00, 0);
        exp_res(RES_ERR);
        send_byte(8'hB4, 0);
        settle("bad_chk");
        check("bad_chk_error", int'(err_a), 1);
        check("bad_chk_hold", int'(hold_a), 1);

        // From ERR: Start ignored mid INS_LO, then a good one-word image.
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        pulse_start();
        check("start_in_ins_lo_ready", int'(rdy_a), 1);
        exp_wr(0, 'h155);
        send_byte(8'h55, 0); send_byte(8'h01, 0);
        exp_res(RES_DONE);
        send_byte(8'h54, 0);
        settle("restart");
        check("restart_done", int'(done_a), 1);
        check("restart_error", int'(err_a), 0);

        // Narrow instance: 17 words exceeds 16-word capacity.
        sel = 1'b1;
        pulse_start();
        exp_res(RES_ERR);
        send_byte(8'h11, 0); send_byte(8'h00, 0);
        settle("len17");
        check("len17_error", int'(err_b), 1);

        // Full capacity: 16 words to addresses 0..15.
        pulse_start();
        send_byte(8'h10, 0); send_byte(8'h00, 0);
        ck = 8'h00;
        for (int i = 0; i < 16; i++) begin
            w = 9'((i * 37 + 5) % 512);
            exp_wr(i, int'(w));
            ck = ck ^ w[7:0] ^ {7'd0, w[8]};
            send_byte(w[7:0], 0);
            send_byte({7'd0, w[8]}, 0);
        end
        exp_res(RES_DONE);
        send_byte(ck, 0);
        settle("full");
        check("full_done", int'(done_b), 1);
        check("full_hold", int'(hold_b), 0);

        // Async reset while waiting for an INS_HI byte, between clock edges.
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        check("pre_reset_ready", int'(rdy_b), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_ready", int'(rdy_b), 0);
        check("async_addr", int'(addr_b), 0);
        check("async_wdata", int'(data_b), 0);
        check("async_hold", int'(hold_b), 1);
        check("async_error", int'(err_b), 0);
        check("async_wren", int'(wr_b), 0);
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rxvalid = 1'b1;
        rxdata  = 8'h01;
        repeat (4) @(posedge clk);
        #1;
        rxvalid = 1'b0;
        check("idle_after_reset_ready", int'(rdy_b), 0);
        check("idle_after_reset_done", int'(done_b), 0);
        exp_wr(0, 'h1AA);
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'h01, 0);
        exp_res(RES_DONE);
        send_byte(8'hAB, 0);
        settle("post_reset");
        check("post_reset_done", int'(done_b), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction path: receives a program image as a byte stream and writes 9-bit machine-code words into the instruction memory that the fetch unit reads and the control decoder consumes.
- Holds the core in hold (CoreHold=1) until a complete image has been written and its checksum verified.
- Sits between the host byte link (valid/ready) and the instruction memory write port.

Parameters:
- ADDR_W, 10, instruction memory address width; capacity MAX_WORDS = 2**ADDR_W.

Ports:
- Clk  input  1  system clock, all state on rising edge
- Reset_n  input  1  asynchronous active-low reset
- Start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
- RxValid  input  1  byte on RxData is valid
- RxData  input  8  stream byte
- RxReady  output  1  loader accepts a byte this cycle; transfer occurs when RxValid&RxReady
- ImemWrEn  output  1  instruction memory write strobe
- ImemAddr  output  ADDR_W  write address
- ImemWrData  output  9  instruction word
- CoreHold  output  1  keep fetch unit/core stalled
- Done  output  1  image loaded and checksum good (sticky)
- Error  output  1  load failed (sticky)

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (Reset_n).
- Reset values: state=IDLE, RxReady=0, ImemWrEn=0, ImemAddr=0, ImemWrData=0, CoreHold=1, Done=0, Error=0. Reset_n low mid-load aborts immediately; no further writes occur.
- Stream format: LEN_LO, LEN_HI (16-bit word count N), then N pairs {LO = instr[7:0], HI = {7'b0, instr[8]}}, then one CHK byte = XOR of all 2N instruction bytes. Length bytes are not included in the checksum.
- States: IDLE, LEN_LO, LEN_HI, INS_LO, INS_HI, WRITE, CHECK, DONE, ERR.
- IDLE/DONE/ERR: RxReady=0. Start -> LEN_LO. Entering LEN_LO clears Done, Error, the word counter and the checksum accumulator, and sets CoreHold=1.
- LEN_LO, LEN_HI, INS_LO, INS_HI, CHECK: RxReady=1. The state advances only on an accepted byte; with RxValid low the state holds indefinitely.
- After LEN_HI is accepted: N==0 or N>MAX_WORDS -> ERR; otherwise -> INS_LO.
- INS_HI accept: RxData[7:1]!=0 -> ERR, no write. Otherwise latch the word and go to WRITE.
- WRITE (exactly one cycle, RxReady=0):
  - ImemWrEn=1, ImemAddr=counter, ImemWrData=assembled word.
  - Latency: the write strobe occurs in the cycle after the HI byte is accepted.
  - Counter increments. If new counter==N -> CHECK, else -> INS_LO.
  - ImemWrEn is 0 in every other state. ImemAddr/ImemWrData may hold their last values.
- CHECK accept: RxData==accumulator -> DONE (Done=1, CoreHold=0); mismatch -> ERR (Error=1, CoreHold=1).
- Start is ignored in all receive states and in WRITE.
- Done and Error are never 1 simultaneously.
- Counter width is ADDR_W+1 so that N==MAX_WORDS terminates without wrap; the last address written is MAX_WORDS-1.
- ERR leaves any already-written words in memory. CoreHold stays 1 until a later load ends in DONE.

Test Plan:
- Nominal load: Start, bytes 02 00 | 34 01 | 80 00 | CHK=B5 -> writes addr0=0x134, addr1=0x080 on the cycle after each HI byte; then Done=1, CoreHold=0, Error=0.
- Backpressure/gaps: same image with RxValid deasserted 3 cycles between every byte -> identical writes and result; RxReady=0 during each WRITE cycle; no byte lost or duplicated.
- Bad length: LEN 00 00 -> Error=1, no ImemWrEn. Separately, with ADDR_W=4, LEN 11 00 (17) -> Error=1. Full-capacity case: ADDR_W=4, N=16 -> 16 writes to addrs 0..15, then Done.
- Format/checksum errors: HI byte 0x03 -> Error=1, no write for that word. Correct image with CHK wrong by one bit -> Error=1, CoreHold=1, all words written.
- Restart/Start handling: Start during INS_LO is ignored (no state change). From ERR, Start then a good image -> Done=1 and Error cleared.
- Async reset: assert Reset_n low mid-INS_HI without a clock edge -> outputs go to reset values immediately; after release, only a new Start resumes operation.
